alu_operand_stage: RTL
======================

# alu_operand_stage

Issue stage that sits directly upstream of the 16-bit ALU. It accepts 16-bit instructions over a valid/ready handshake and decodes them. It reads operands from an internal 8×16 register file and presents registered `i_op1`/`i_op2`/`selector` values to the ALU. A busy-bit scoreboard stalls instructions whose registers still await ALU write-back, and the ALU result returns through the write-back port into the register file.

## Interface
- `DATA_W`, 16, operand/register width.
- `NREGS`, 8, number of registers; r0 reads as zero.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_instr`  in  16  instruction: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [7:0] imm8 (LDI only).
- `i_instr_valid`  in  1  instruction present.
- `o_instr_ready`  out  1  stage can accept `i_instr` this cycle.
- `o_op1`  out  16  to ALU `i_op1`.
- `o_op2`  out  16  to ALU `i_op2`.
- `o_sel`  out  3  to ALU `selector`.
- `o_rd`  out  3  destination tag travelling with the op.
- `o_valid`  out  1  one-cycle pulse per issued ALU op.
- `i_wb_en`  in  1  write-back strobe.
- `i_wb_addr`  in  3  write-back register.
- `i_wb_data`  in  32  ALU `Result_op`; only bits [15:0] are written.
- `o_illegal`  out  1  one-cycle pulse when opcode 110/111 is accepted.

## Operation
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR: ALU ops, sel = opcode.
  - 100 NOP.
  - 101 LDI: rd ← {8'h00, imm8}, written locally and never sent to the ALU.
  - 110/111: illegal.
- Accept = `i_instr_valid & o_instr_ready` at a rising edge.
- Scoreboard: `busy[NREGS-1:0]`. `busy[0]` is always 0.
  - An issued ALU op sets `busy[rd]`.
  - `i_wb_en` clears `busy[i_wb_addr]`.
  - Same-cycle set and clear of the same index: set wins.
- Effective busy = `busy & ~(i_wb_en ? onehot(i_wb_addr) : 0)`.
- `o_instr_ready` is combinational on `i_instr`.
  - ALU ops are blocked if rs1, rs2 or rd is effectively busy.
  - LDI is blocked if rd is effectively busy.
  - NOP and illegal opcodes are always ready.
- Register read is write-through: if `i_wb_en` and `i_wb_addr` equals a source register in the same cycle, the operand is `i_wb_data[15:0]`.
  - r0 always reads 0.
  - Writes to r0, from either write-back or LDI, are discarded.
- A write-back is always performed, whether or not the busy bit was set.
- LDI and write-back to the same rd in the same cycle cannot occur; the rd busy check forbids it.
- Accepted NOP: no issue, `o_valid` = 0, and no register or scoreboard change.
- Accepted illegal opcode: behaves as NOP and additionally pulses `o_illegal`.
- Widths: the register file is DATA_W wide. Write-back truncates 32 bits to [15:0] with no saturation.

## Timing
- Reset, asynchronous: all registers and busy bits are cleared.
- Output values during reset:
  - `o_op1` = 0, `o_op2` = 0, `o_rd` = 0.
  - `o_sel` = 3'b100 (NOP), so the ALU holds its value.
  - `o_valid` = 0, `o_illegal` = 0.
- Reset mid-stall drops the pending instruction and all busy bits.
- A write-back arriving after reset is still written.
- Issue latency: an ALU op accepted at edge N drives `o_op1`, `o_op2`, `o_sel`, `o_rd` and `o_valid` = 1 after edge N. They are valid for exactly one cycle.
- When `o_valid` = 0, `o_op*`, `o_rd` and `o_sel` hold their last values.
- LDI accepted at edge N is readable by an instruction accepted at edge N+1.
- Throughput: one instruction per cycle when there are no hazards.
- A dependent op stalls until the cycle in which its write-back strobe is seen. It is accepted at that edge with the bypassed operand.
- `i_instr` must be held stable while `i_instr_valid` = 1 and `o_instr_ready` = 0.

## Test plan
- **Reset:** assert `i_rst_n` = 0 mid-cycle -> outputs take their reset values immediately; `o_sel` = 100; every register reads 0.
- **LDI then ADD:** LDI r1,10; LDI r2,22; ADD r3,r1,r2 -> one cycle after the ADD is accepted, `o_op1` = 10, `o_op2` = 22, `o_sel` = 000, `o_rd` = 3, `o_valid` = 1.
- **RAW stall:**
  - Stimulus: after the ADD above, present SUB r4,r3,r3.
  - Required: `o_instr_ready` = 0 until the bench drives `i_wb_en`=1, `i_wb_addr`=3, `i_wb_data`=32'd32.
  - Then the SUB is accepted that same edge with `o_op1` = `o_op2` = 32.
- **Write-back truncation and r0:**
  - Stimulus: write-back r5 with 32'h0001_FFFF, then OR r6,r5,r0.
  - Required: `o_op1` = 16'hFFFF and `o_op2` = 0.
  - Stimulus: write-back to r0 with 7, then read r0.
  - Required: r0 still reads 0.
- **NOP and illegal:**
  - Stimulus: instruction 16'h8000 (NOP).
  - Required: accepted, `o_valid` = 0, `o_sel` unchanged.
  - Stimulus: instruction 16'hE000 (illegal).
  - Required: `o_illegal` pulses for one cycle; no register or busy change.
- **Set/clear collision:**
  - Setup: r3 is busy.
  - Stimulus: in the same cycle, write-back r3 and present ADD r3,r1,r2.
  - Required: the ADD is accepted and `busy[3]` remains 1 afterwards.

Source files
------------

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Issue stage in front of the 16-bit ALU. Decodes 16-bit instructions taken
// over a valid/ready handshake, reads operands from an 8 x DATA_W register
// file and presents registered operands, selector and destination tag to the
// ALU. A busy-bit scoreboard stalls instructions that touch registers still
// waiting for ALU write-back; write-back returns through i_wb_*.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_instr        [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [7:0] imm8
//   i_instr_valid  instruction present
//   o_instr_ready  instruction can be accepted this cycle (combinational)
//   o_op1/o_op2    operands to the ALU
//   o_sel          ALU selector (3'b100 = NOP while idle after reset)
//   o_rd           destination tag travelling with the op
//   o_valid        one-cycle pulse per issued ALU op
//   i_wb_en        write-back strobe
//   i_wb_addr      write-back register
//   i_wb_data      ALU result; only the low DATA_W bits are kept
//   o_illegal      one-cycle pulse when opcode 110/111 is accepted
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_instr,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic [2:0]        o_sel,
  output logic [2:0]        o_rd,
  output logic              o_valid,
  input  logic              i_wb_en,
  input  logic [2:0]        i_wb_addr,
  input  logic [31:0]       i_wb_data,
  output logic              o_illegal
);

  localparam logic [2:0] OPC_NOP = 3'b100;
  localparam logic [2:0] OPC_LDI = 3'b101;

  // Write-back keeps the low DATA_W bits; no saturation.
  function automatic logic [DATA_W-1:0] trunc_wb(input logic [31:0] d);
    return d[DATA_W-1:0];
  endfunction

  function automatic logic [NREGS-1:0] onehot(input logic [2:0] a);
    logic [NREGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;

  logic [DATA_W-1:0] r_op1_p1;
  logic [DATA_W-1:0] r_op2_p1;
  logic [2:0]        r_sel_p1;
  logic [2:0]        r_rd_p1;
  logic              r_vld_p1;
  logic              r_ill_p1;

  // ---------------------------------------------------------------------------
  // Stage p0: decode, hazard check, operand read
  // ---------------------------------------------------------------------------
  logic [2:0]        w_opc;
  logic [2:0]        w_rd;
  logic [2:0]        w_rs1;
  logic [2:0]        w_rs2;
  logic [7:0]        w_imm;
  logic              w_is_alu;
  logic              w_is_ldi;
  logic              w_is_ill;
  logic [NREGS-1:0]  w_wb_mask;
  logic [NREGS-1:0]  w_eff_busy;
  logic              w_ready;
  logic              w_accept;
  logic              w_issue;
  logic              w_ldi_wr;
  logic [DATA_W-1:0] w_wb_val;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic [NREGS-1:0]  w_busy_nxt;
  logic              w_unused;

  assign w_opc    = i_instr[15:13];
  assign w_rd     = i_instr[12:10];
  assign w_rs1    = i_instr[9:7];
  assign w_rs2    = i_instr[6:4];
  assign w_imm    = i_instr[7:0];
  assign w_is_alu = ~w_opc[2];
  assign w_is_ldi = (w_opc == OPC_LDI);
  assign w_is_ill = (w_opc[2:1] == 2'b11);
  assign w_wb_val = trunc_wb(i_wb_data);
  assign w_unused = &{1'b0, i_wb_data[31:16]};

  // A register being written back this cycle is already free: that is what
  // lets a dependent op issue in the very cycle its result arrives.
  assign w_wb_mask  = i_wb_en ? onehot(i_wb_addr) : '0;
  assign w_eff_busy = r_busy & ~w_wb_mask;

  always_comb begin
    w_ready = 1'b1;
    if (w_is_alu) begin
      w_ready = ~(w_eff_busy[w_rs1] | w_eff_busy[w_rs2] | w_eff_busy[w_rd]);
    end else if (w_is_ldi) begin
      w_ready = ~w_eff_busy[w_rd];
    end
  end

  assign o_instr_ready = w_ready;
  assign w_accept      = i_instr_valid & w_ready;
  assign w_issue       = w_accept & w_is_alu;
  assign w_ldi_wr      = w_accept & w_is_ldi & (w_rd != 3'd0);

  // Write-through read: a same-cycle write-back is forwarded to the operand.
  always_comb begin
    w_op1 = r_regs[w_rs1];
    w_op2 = r_regs[w_rs2];
    if (i_wb_en && (i_wb_addr == w_rs1)) w_op1 = w_wb_val;
    if (i_wb_en && (i_wb_addr == w_rs2)) w_op2 = w_wb_val;
    if (w_rs1 == 3'd0) w_op1 = '0;
    if (w_rs2 == 3'd0) w_op2 = '0;
  end

  // Clear first, then set, so a same-cycle set of the same index wins.
  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_mask;
    if (w_issue) w_busy_nxt = w_busy_nxt | onehot(w_rd);
    w_busy_nxt[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Register file and scoreboard
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (i_wb_en && (i_wb_addr != 3'd0)) r_regs[i_wb_addr] <= w_wb_val;
      if (w_ldi_wr) r_regs[w_rd] <= {{(DATA_W-8){1'b0}}, w_imm};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered ALU-facing outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op1_p1 <= '0;
      r_op2_p1 <= '0;
      r_sel_p1 <= OPC_NOP;
      r_rd_p1  <= 3'd0;
      r_vld_p1 <= 1'b0;
      r_ill_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue;
      r_ill_p1 <= w_accept & w_is_ill;
      // Operands hold between issues so the ALU sees stable inputs.
      if (w_issue) begin
        r_op1_p1 <= w_op1;
        r_op2_p1 <= w_op2;
        r_sel_p1 <= w_opc;
        r_rd_p1  <= w_rd;
      end
    end
  end

  assign o_op1     = r_op1_p1;
  assign o_op2     = r_op2_p1;
  assign o_sel     = r_sel_p1;
  assign o_rd      = r_rd_p1;
  assign o_valid   = r_vld_p1;
  assign o_illegal = r_ill_p1;

endmodule
